// File: rtl/bcd_to_binary_converter.sv
// Seven-digit BCD to 32-bit two's-complement converter using reverse double-dabble.
// Optional input digit checking is enabled by defining BCD2BIN_DIGIT_CHECK_EN.
module bcd_to_binary_converter (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        negative,
  input  logic [3:0]  first,
  input  logic [3:0]  second,
  input  logic [3:0]  third,
  input  logic [3:0]  fourth,
  input  logic [3:0]  fifth,
  input  logic [3:0]  sixth,
  input  logic [3:0]  seventh,
  output logic [31:0] binary,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  state_dbg
);

  // Handshake: start is a level request honoured only in IDLE; the result in
  // binary/error is valid during the single-cycle done pulse and held afterwards.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    SIGN  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [27:0] bcd_q, bcd_d;
  logic [31:0] accum_q, accum_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        sign_q, sign_d;
  logic [31:0] binary_q, binary_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [27:0] bcd_shifted;
  logic [27:0] bcd_adj;
  logic [31:0] magnitude;

`ifdef BCD2BIN_DIGIT_CHECK_EN
  logic err_q, err_d;
  logic error_q, error_d;
  logic digit_bad;

  always_comb begin
    digit_bad = (first > 4'd9) || (second > 4'd9) || (third > 4'd9) ||
                (fourth > 4'd9) || (fifth > 4'd9) || (sixth > 4'd9) ||
                (seventh > 4'd9);
  end
`endif

  // One reverse double-dabble step: shift right, then correct digits >= 8.
  always_comb begin
    bcd_shifted = {1'b0, bcd_q[27:1]};
    bcd_adj     = bcd_shifted;
    for (int i = 0; i < 7; i++) begin
      if (bcd_shifted[4*i +: 4] >= 4'd8) begin
        bcd_adj[4*i +: 4] = bcd_shifted[4*i +: 4] - 4'd3;
      end
    end
  end

  assign magnitude = {4'd0, accum_q[31:4]};

  always_comb begin
    state_d  = state_q;
    bcd_d    = bcd_q;
    accum_d  = accum_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    binary_d = binary_q;
`ifdef BCD2BIN_DIGIT_CHECK_EN
    err_d    = err_q;
    error_d  = error_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          bcd_d   = {seventh, sixth, fifth, fourth, third, second, first};
          sign_d  = negative;
          accum_d = 32'd0;
          cnt_d   = 5'd0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
          err_d   = digit_bad;
`endif
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d   = bcd_adj;
        accum_d = {bcd_q[0], accum_q[31:1]};
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == 5'd27) begin
          state_d = SIGN;
        end
      end
      SIGN: begin
        binary_d = sign_q ? magnitude : (~magnitude + 32'd1);
`ifdef BCD2BIN_DIGIT_CHECK_EN
        error_d  = err_q;
        if (err_q) begin
          binary_d = 32'd0;
        end
`endif
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == SHIFT) || (state_d == SIGN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      bcd_q    <= 28'd0;
      accum_q  <= 32'd0;
      cnt_q    <= 5'd0;
      sign_q   <= 1'b0;
      binary_q <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
      err_q    <= 1'b0;
      error_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      bcd_q    <= bcd_d;
      accum_q  <= accum_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      binary_q <= binary_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef BCD2BIN_DIGIT_CHECK_EN
      err_q    <= err_d;
      error_q  <= error_d;
`endif
    end
  end

  assign binary    = binary_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state_dbg = state_q;
`ifdef BCD2BIN_DIGIT_CHECK_EN
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_binary_converter.sv
// Directed bench for bcd_to_binary_converter with an expected-result queue
// popped on every done pulse; checks value, error, latency and busy length.
module tb_bcd_to_binary_converter;

  logic        clk;
  logic        reset;
  logic        start;
  logic        negative;
  logic [27:0] din;
  logic [31:0] binary;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int busy_cnt = 0;

  // {check_binary, error, binary}
  logic [33:0] exp_q[$];
  int          st_q[$];

  bcd_to_binary_converter dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .negative  (negative),
    .first     (din[3:0]),
    .second    (din[7:4]),
    .third     (din[11:8]),
    .fourth    (din[15:12]),
    .fifth     (din[19:16]),
    .sixth     (din[23:20]),
    .seventh   (din[27:24]),
    .binary    (binary),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [27:0] d, input logic neg);
    logic [31:0] mag;
    logic [31:0] p;
    mag = 32'd0;
    p   = 32'd1;
    for (int i = 0; i < 7; i++) begin
      mag = mag + 32'(d[4*i +: 4]) * p;
      p   = p * 32'd10;
    end
    return neg ? mag : (32'd0 - mag);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic start_conv(input logic [27:0] d, input logic neg, input logic push,
                            input logic chk_bin, input logic exp_err, input logic [31:0] exp_bin);
    @(negedge clk);
    din      = d;
    negative = neg;
    start    = 1'b1;
    @(posedge clk);
    #1;
    if (push) begin
      exp_q.push_back({chk_bin, exp_err, exp_bin});
      st_q.push_back(cyc);
    end
    @(negedge clk);
    start = 1'b0;
    din   = $urandom_range(0, 32'h0FFF_FFFF);
    negative = $urandom_range(0, 1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("wait_timeout", exp_q.size(), 0);
      exp_q.delete();
      st_q.delete();
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  // done appears in the cycle after edge k+29, i.e. 29 counted edges after the start edge.
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", done, 1'b0);
      end else begin
        logic [33:0] e;
        int          s;
        e = exp_q.pop_front();
        s = st_q.pop_front();
        if (e[33]) check("binary", binary, e[31:0]);
        check("error", error, 32'(e[32]));
        check("latency", cyc - s, 29);
        check("busy_len", busy_cnt, 29);
      end
      busy_cnt = 0;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [27:0] d;
    logic        n;
    int          st;

    reset    = 1'b1;
    start    = 1'b0;
    negative = 1'b0;
    din      = 28'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_binary", binary, 32'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_state", state_dbg, 2'd0);
    reset = 1'b0;
    busy_cnt = 0;

    start_conv(28'h1234567, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0012D687);
    wait_done();
    repeat (3) @(negedge clk);
    check("hold_binary", binary, 32'h0012D687);
    check("idle_busy", busy, 1'b0);

    start_conv(28'h9999999, 1'b0, 1'b1, 1'b1, 1'b0, 32'hFF676981);
    wait_done();
    start_conv(28'h0000000, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000);
    wait_done();
    start_conv(28'h0000001, 1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF);
    wait_done();

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 7; i++) d[4*i +: 4] = 4'($urandom_range(0, 9));
      n = 1'($urandom_range(0, 1));
      start_conv(d, n, 1'b1, 1'b1, 1'b0, model(d, n));
      wait_done();
    end

    // start held high: second request accepted 31 edges after the first
    @(negedge clk);
    din = 28'h0000042; negative = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    st = cyc;
    exp_q.push_back({1'b1, 1'b0, 32'd42});
    st_q.push_back(st);
    @(negedge clk);
    din = 28'h0031415; negative = 1'b0;
    repeat (31) @(posedge clk);
    #1;
    exp_q.push_back({1'b1, 1'b0, model(28'h0031415, 1'b0)});
    st_q.push_back(st + 31);
    @(negedge clk);
    start = 1'b0; din = 28'h8888888; negative = 1'b1;
    wait_done();

    // reset in the middle of a conversion: no done, outputs cleared
    start_conv(28'h7654321, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_binary", binary, 32'd0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_error", error, 1'b0);
    reset = 1'b0;
    busy_cnt = 0;
    repeat (40) @(negedge clk);
    start_conv(28'h0000005, 1'b1, 1'b1, 1'b1, 1'b0, 32'h00000005);
    wait_done();

    // start coincident with reset is ignored
    @(negedge clk);
    reset = 1'b1; start = 1'b1; din = 28'h0000123;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_start_busy", busy, 1'b0);
    check("rst_start_state", state_dbg, 2'd0);
    busy_cnt = 0;

    // invalid digit
`ifdef BCD2BIN_DIGIT_CHECK_EN
    start_conv(28'h0000A00, 1'b1, 1'b1, 1'b1, 1'b1, 32'h00000000);
`else
    start_conv(28'h0000A00, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00000000);
`endif
    wait_done();
    start_conv(28'h0000909, 1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFFFC73);
    wait_done();

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_to_binary_converter.md
BCD_TO_BINARY_CONVERTER -- requirements
Module: bcd_to_binary_converter

Interface
REQ-001 The block SHALL have a single clock and a synchronous active-high reset; the ports are clk (rising edge) and reset.
REQ-002 clk  input  1  system clock.
REQ-003 reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
REQ-004 start  input  1  request a conversion; sampled only in IDLE.
REQ-005 negative  input  1  sign flag; 0 means the value is negative, 1 means non-negative.
REQ-006 first, second, third, fourth, fifth, sixth, seventh  input  4 each  BCD digits; first is the ones digit, seventh is the millions digit.
REQ-007 binary  output  32  two's-complement result, registered.
REQ-008 busy  output  1  high while a conversion is in progress.
REQ-009 done  output  1  one-cycle pulse; binary is valid while done is high.
REQ-010 error  output  1  an invalid digit was detected; valid while done is high.

Function
REQ-011 The block SHALL implement the states IDLE, SHIFT, SIGN and DONE.
REQ-012 IDLE SHALL behave as follows:
- When start=1, the block latches all seven digits and negative into a 28-bit BCD shift register and a sign register.
- It clears the 32-bit accumulator and the 5-bit counter, then moves to SHIFT.
REQ-013 Each SHIFT cycle SHALL perform one reverse double-dabble step:
- Shift the BCD register right by 1; its LSB enters accumulator bit 31 as the accumulator shifts right.
- Then subtract 3 from every 4-bit BCD digit whose value is 8 or greater.
REQ-014 After 28 SHIFT cycles, accum[31:4] SHALL hold the unsigned magnitude, which is at most 9,999,999; the block then moves to SIGN.
REQ-015 SIGN SHALL write binary:
- The magnitude, when the latched sign is 1.
- Its two's complement (~magnitude + 1), when the latched sign is 0.
- Negative zero yields 0x00000000.
REQ-016 Leaving SIGN, the block SHALL assert done=1 for exactly one cycle in DONE, then return to IDLE.
REQ-017 Timing SHALL be fixed for every conversion:
- start is sampled at edge k.
- done is high in the cycle after edge k+29.
- busy is high from edge k+1 through edge k+29.
- The next start is accepted no earlier than edge k+31.
REQ-018 start SHALL be ignored in SHIFT, SIGN and DONE.
REQ-019 Input changes after the start edge SHALL NOT affect the result.
REQ-020 binary and error SHALL hold their values from the last done until the next SIGN write or reset.
REQ-021 All arithmetic SHALL be unsigned within the widths stated above; no saturation is needed because the maximum magnitude fits in 24 bits.

Reset
REQ-022 On reset=1 at any edge, including mid-conversion, the block SHALL return to IDLE.
REQ-023 The following SHALL be cleared on reset:
- binary = 0, busy = 0, done = 0, error = 0.
- Shift, accumulator and counter registers.
REQ-024 After reset, no done pulse SHALL occur for an aborted conversion.
REQ-025 A start that is high in the same cycle as reset SHALL be ignored.

Configuration
REQ-026 The macro BCD2BIN_DIGIT_CHECK_EN SHALL be defined as follows:
- When defined: at start acceptance, any digit greater than 9 sets the latched error flag, and SIGN then writes binary=0 and error=1.
- Timing is unchanged.
REQ-027 Without BCD2BIN_DIGIT_CHECK_EN:
- error SHALL be tied to 0.
- Digits greater than 9 SHALL be processed by the REQ-013 algorithm unmodified, with no checking logic synthesized.

Verification
REQ-028 Digits 7,6,5,4,3,2,1 (first..seventh) with negative=1, start pulsed -> binary=0x0012D687 (1234567), done high exactly 30 cycles after start, error=0.
REQ-029 All digits 9 with negative=0 -> binary=0xFF676981 (-9999999); busy high for 29 cycles.
REQ-030 All digits 0 with negative=0 -> binary=0x00000000.
REQ-031 start held high continuously -> conversions complete every 31 cycles; start during busy is ignored and the inputs it carries do not alter the in-flight result.
REQ-032 reset asserted at cycle 10 of a conversion -> all outputs 0 next cycle and no done pulse; a following start of digit 5 only (first=5) -> binary=0x00000005.
REQ-033 With BCD2BIN_DIGIT_CHECK_EN, third=0xA and other digits 0 -> done after 30 cycles with error=1 and binary=0; without the macro, error stays 0.
